// File: rtl/pckthandler_pkg.sv
// Shared CSI-2 packet handler definitions: data types, parser states
// and small header-decoding helpers.
package pckthandler_pkg;

    typedef logic [5:0] dt_t;

    localparam dt_t DT_FS       = 6'h00;
    localparam dt_t DT_FE       = 6'h01;
    localparam dt_t DT_LS       = 6'h02;
    localparam dt_t DT_LE       = 6'h03;
    localparam dt_t DT_LONG_MIN = 6'h10;
    localparam dt_t DT_RAW8     = 6'h2A;
    localparam dt_t DT_RAW10    = 6'h2B;

    typedef enum logic [1:0] {
        IDLE,
        HDR2,
        PAYLOAD,
        FOOTER
    } state_t;

    function automatic logic is_short(input dt_t dt);
        return dt < DT_LONG_MIN;
    endfunction

    // Payload words minus one: ceil(wc/2)-1 always fits 15 bits.
    function automatic logic [14:0] words_m1(input logic [15:0] wc);
        logic [15:0] t;
        t = wc - 16'd1;
        return t[15:1];
    endfunction

endpackage

// File: rtl/pckthandler.sv
// CSI-2 packet parser: strips header/footer, forwards long-packet
// payload inside a frame, tracks frame state from FS/FE.
module pckthandler
    import pckthandler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic [15:0] dout,
    output logic        fr_active,
    output logic        fr_valid
);

    state_t      state;
    dt_t         dt;
    logic [7:0]  wc_lo;
    logic [14:0] cnt;
    logic [15:0] wc;

    assign wc = {din[15:8], wc_lo};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dt        <= '0;
            wc_lo     <= '0;
            cnt       <= '0;
            dout      <= '0;
            fr_active <= 1'b0;
            fr_valid  <= 1'b0;
        end else begin
            fr_valid <= 1'b0;
            // A gap aborts any packet in flight.
            if (!din_valid) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        dt    <= din[13:8];
                        wc_lo <= din[7:0];
                        state <= HDR2;
                    end
                    HDR2: begin
                        if (is_short(dt)) begin
                            if (dt == DT_FS)
                                fr_active <= 1'b1;
                            else if (dt == DT_FE)
                                fr_active <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt   <= words_m1(wc);
                            state <= (wc == 16'd0) ? FOOTER : PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (fr_active) begin
                            dout     <= din;
                            fr_valid <= 1'b1;
                        end
                        if (cnt == 15'd0)
                            state <= FOOTER;
                        else
                            cnt <= cnt - 15'd1;
                    end
                    FOOTER: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pckthandler.sv
// Scoreboard bench for pckthandler: directed packets, expected
// payload words queued at issue and checked by a monitor.
module tb_pckthandler;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        din_valid;
    logic [15:0] dout;
    logic        fr_active;
    logic        fr_valid;

    int n_tests;
    int n_fail;
    logic [15:0] exp_q[$];

    pckthandler dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .fr_active (fr_active),
        .fr_valid  (fr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid output word must match the queue head.
    always @(negedge clk) begin
        if (reset && fr_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got %h, required no output", dout);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL payload: got %h, required %h", dout, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic send(input logic [15:0] w);
        din       = w;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        din_valid = 1'b0;
        din       = 16'h0000;
        @(posedge clk);
        #1;
    endtask

    task automatic send_fs();
        send(16'h0000);
        send(16'h0055);
    endtask

    task automatic send_fe();
        send(16'h0100);
        send(16'h0066);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        din_valid = 1'b1;
        din       = 16'h0000;

        // Reset with live random traffic
        for (int i = 0; i < 4; i++) begin
            din = 16'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_dout", dout, 16'h0000);
        chk("rst_active", {15'd0, fr_active}, 16'd0);
        chk("rst_valid", {15'd0, fr_valid}, 16'd0);
        din_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;

        // Long packet outside a frame is swallowed
        send(16'h2A04);
        send(16'h0012);
        send(16'h1122);
        send(16'h3344);
        send(16'hBEEF);
        chk("pre_fs_active", {15'd0, fr_active}, 16'd0);

        send_fs();
        chk("fs_active", {15'd0, fr_active}, 16'd1);
        send_fe();
        chk("fe_active", {15'd0, fr_active}, 16'd0);
        send_fs();
        chk("fs2_active", {15'd0, fr_active}, 16'd1);

        // Long packet in a frame
        send(16'h2A04);
        send(16'h0012);
        exp_q.push_back(16'h1122);
        send(16'h1122);
        exp_q.push_back(16'h3344);
        send(16'h3344);
        send(16'hBEEF);
        chk("hold_dout", dout, 16'h3344);
        chk("hold_valid", {15'd0, fr_valid}, 16'd0);
        chk("in_frame_active", {15'd0, fr_active}, 16'd1);

        // WC = 0: header then CRC only
        send(16'h2B00);
        send(16'h0000);
        send(16'hCCCC);
        send_fe();
        chk("wc0_fe_active", {15'd0, fr_active}, 16'd0);

        // Abort mid-payload, then FE
        send_fs();
        send(16'h2A08);
        send(16'h0000);
        exp_q.push_back(16'hA1A2);
        send(16'hA1A2);
        exp_q.push_back(16'hA3A4);
        send(16'hA3A4);
        gap();
        chk("gap_valid", {15'd0, fr_valid}, 16'd0);
        send_fe();
        chk("abort_fe_active", {15'd0, fr_active}, 16'd0);

        // Odd WC forwards the padded final word
        send_fs();
        send(16'h2A03);
        send(16'h0000);
        exp_q.push_back(16'h5566);
        send(16'h5566);
        exp_q.push_back(16'h7788);
        send(16'h7788);
        send(16'h9999);
        send_fe();
        chk("odd_fe_active", {15'd0, fr_active}, 16'd0);

        // Reset mid-payload clears outputs at once
        send_fs();
        send(16'h2A08);
        send(16'h0000);
        exp_q.push_back(16'h0102);
        send(16'h0102);
        send(16'h0304);
        reset = 1'b0;
        #1;
        chk("midrst_dout", dout, 16'h0000);
        chk("midrst_valid", {15'd0, fr_valid}, 16'd0);
        chk("midrst_active", {15'd0, fr_active}, 16'd0);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        send_fs();
        chk("post_rst_fs", {15'd0, fr_active}, 16'd1);

        gap();
        gap();
        chk("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pckthandler.md
# pckthandler

MIPI CSI-2 packet handler sitting directly after the 2-lane byte aligner in the receive path. It parses short and long packets from a 16-bit byte-pair stream and strips the 4-byte packet header and 2-byte CRC footer. It forwards only long-packet payload words, and only inside a frame. It also tracks frame state from Frame Start and Frame End short packets for the downstream pixel/frame writer.

## Interface
- No parameters.
- `clk`  in  1  Rising-edge clock.
- `reset`  in  1  Asynchronous, active-low reset.
- `din`  in  16  Byte pair. `din[15:8]` is the earlier byte on the wire and `din[7:0]` the later byte.
- `din_valid`  in  1  Qualifies `din`. Low means inter-burst gap (LP state); the word is ignored.
- `dout`  out  16  Payload byte pair, same byte order as `din`.
- `fr_active`  out  1  High between a Frame Start and the following Frame End.
- `fr_valid`  out  1  High on cycles where `dout` holds a payload word. This is the data-valid strobe.

## Operation
- Packet header is 2 words:
  - H1 = {DI, WC[7:0]}
  - H2 = {WC[15:8], ECC}
  - DI[5:0] = data type; DI[7:6] = virtual channel. VC is ignored and all VCs are accepted.
  - ECC is not checked or corrected.
- States:
  - IDLE: the next valid word is H1. Latch DI and WC low byte, go to HDR2.
  - HDR2: latch WC high byte.
    - If data type < 0x10 (short packet), execute it and go to IDLE.
    - Otherwise load word counter = ceil(WC/2). Go to PAYLOAD, or to FOOTER if WC = 0.
  - PAYLOAD: each valid word decrements the counter and is forwarded. When the last word is consumed, go to FOOTER.
  - FOOTER: one valid word (CRC), discarded and never checked, then go to IDLE.
- Short packet actions:
  - 0x00 Frame Start: set `fr_active`.
  - 0x01 Frame End: clear `fr_active`.
  - 0x02/0x03 line start/end and all other short types: no effect.
- Payload forwarding: `fr_valid` is asserted only if `fr_active` is high when the word is accepted. Payload outside a frame is consumed silently.
- Odd WC: the final payload word is forwarded whole, including its pad byte. The footer is taken from the next word. This is a documented limitation; sources send even WC.
- `din_valid` low in any non-IDLE state aborts the packet and returns to IDLE. No output is produced for that cycle and `fr_active` is unchanged. The next valid word is treated as H1.
- `din_valid` low in IDLE: stay in IDLE.
- Word counter is 15 bits, so it covers WC up to 0xFFFF.

## Timing
- Reset (asynchronous, active-low) sets:
  - state = IDLE
  - `dout` = 0x0000
  - `fr_active` = 0
  - `fr_valid` = 0
  - counters = 0
- Reset mid-packet discards the packet. After release, the first valid word is H1.
- All outputs are registered with 1-cycle latency. A payload word sampled at edge k appears on `dout` with `fr_valid` = 1 after edge k, for one cycle.
- `dout` holds its last value when `fr_valid` = 0.
- `fr_active` changes after the edge that samples H2 of FS/FE.
- Back-to-back packets need no gap: the H1 of the next packet may follow the footer word, or the H2 of a short packet, directly.
- Throughput is 1 word per cycle. There is no backpressure.

## Structure
- Shared package holds:
  - Data-type constants: `DT_FS` = 0x00, `DT_FE` = 0x01, `DT_LS` = 0x02, `DT_LE` = 0x03, `DT_LONG_MIN` = 0x10, `DT_RAW8` = 0x2A, `DT_RAW10` = 0x2B.
  - State enum: IDLE, HDR2, PAYLOAD, FOOTER.
- Single module with no sub-modules. A later ECC/CRC checker would be a separate sibling block.

## Test plan
- Reset with `din_valid` = 1 and random `din` -> all outputs 0 during reset. After release, the first word is parsed as H1.
- FS: 0x0000, 0x00xx -> `fr_active` = 1 one cycle after H2. FE: 0x0100, 0x00xx -> `fr_active` = 0 one cycle after H2. `fr_valid` stays 0 throughout.
- Inside a frame, send 0x2A04, 0x0012, 0x1122, 0x3344, 0xBEEF -> `dout` = 0x1122 then 0x3344 with `fr_valid` = 1 on exactly those 2 cycles. 0xBEEF is never output.
- Same long packet sent before FS -> `fr_valid` never asserts, and the next FS is still parsed correctly.
- Long packet WC = 0 (0x2B00, 0x0000, CRC word) -> no output, and the following FE is honoured.
- Drop `din_valid` mid-payload of a WC = 8 packet, then send FE -> packet aborted, FE parsed, `fr_active` = 0. Also assert reset mid-payload -> outputs clear immediately.
